// File: rtl/mips_mem_pkg.sv
// -----------------------------------------------------------------------------
// mips_mem_pkg
// Shared types for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM states (IDLE, BUSY_I, BUSY_D)
//   owner_e     : which requester owns a grant or an outstanding read
//   state_owner : maps an FSM state to the owner of its outstanding read
// -----------------------------------------------------------------------------
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_e;

  // The busy states double as a record of who issued the outstanding read.
  function automatic owner_e state_owner(input arb_state_e s);
    case (s)
      BUSY_I:  return OWN_I;
      BUSY_D:  return OWN_D;
      default: return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mips_mem_arbiter_if
// Bundles the fetch port (i_*), the load/store port (d_*) and the backing
// memory port (m_*) of the memory arbiter.
//   slave  : the arbiter's view (takes requests, drives gnt/rvalid and m_*)
//   master : the environment's view (CPU ports plus memory/bus wrapper)
// Parameters ADDR_W/DATA_W must match the arbiter instance.
// -----------------------------------------------------------------------------
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  // fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [DATA_W-1:0] i_rdata;

  // load/store port
  logic              d_req;
  logic [BE_W-1:0]   d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // backing memory port
  logic              m_req;
  logic [BE_W-1:0]   m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_gnt;
  logic              m_rvalid;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  m_gnt, m_rvalid, m_rdata,
    output i_gnt, i_rvalid, i_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_req, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output m_gnt, m_rvalid, m_rdata,
    input  i_gnt, i_rvalid, i_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_req, m_we, m_addr, m_wdata
  );

endinterface

// File: rtl/mips_mem_arbiter_starve_ctr.sv
// -----------------------------------------------------------------------------
// mips_starve_ctr
// Saturating counter of consecutive data grants while fetch is waiting.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : count one more data grant (ignored once saturated)
//   clr      : return to zero; wins over inc
//   at_max   : counter has reached MAX, fetch must win the next tie
// MAX must be at least 1.
// -----------------------------------------------------------------------------
module mips_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  assign at_max = (cnt == W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips_mem_arbiter.sv
// -----------------------------------------------------------------------------
// mips_mem_arbiter
// Shares one single-ported memory between the instruction-fetch port and the
// load/store port. Data wins ties unless fetch has been passed over
// STARVE_MAX times in a row. At most one read is outstanding; its response is
// routed combinationally back to the port that issued it.
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : i_* fetch port, d_* data port, m_* memory port (slave view)
//   protocol_err : sticky, set when memory returns data with no read pending
// Requesters hold req/addr/data until gnt; nothing on the request side is
// latched here, so grants and the memory request are purely combinational.
// -----------------------------------------------------------------------------
module mips_mem_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_mem_arbiter_if.slave    bus,
  output logic                 protocol_err
);

  arb_state_e state_q, state_d;
  owner_e     winner;
  owner_e     rd_owner;
  logic       issue_win;
  logic       d_is_read;
  logic       starve_at_max;
  logic       starve_inc;
  logic       starve_clr;

  assign d_is_read = (bus.d_we == '0);
  assign rd_owner  = state_owner(state_q);

  // The issue window also opens in the response cycle of a busy state so a
  // new read can go out with no bubble behind the one completing.
  always_comb begin
    winner    = OWN_NONE;
    issue_win = (state_q == IDLE) || bus.m_rvalid;
    if (issue_win) begin
      if (bus.d_req && !(bus.i_req && starve_at_max)) begin
        winner = OWN_D;
      end else if (bus.i_req) begin
        winner = OWN_I;
      end
    end
  end

  // Memory request mux, grants and response routing.
  always_comb begin
    bus.m_req   = 1'b0;
    bus.m_we    = '0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    case (winner)
      OWN_I: begin
        bus.m_req  = 1'b1;
        bus.m_addr = bus.i_addr;
      end
      OWN_D: begin
        bus.m_req   = 1'b1;
        bus.m_we    = bus.d_we;
        bus.m_addr  = bus.d_addr;
        bus.m_wdata = bus.d_wdata;
      end
      default: ;
    endcase

    bus.i_gnt = bus.m_gnt && bus.m_req && (winner == OWN_I);
    bus.d_gnt = bus.m_gnt && bus.m_req && (winner == OWN_D);

    // A response in IDLE has no owner and is dropped here.
    bus.i_rvalid = bus.m_rvalid && (rd_owner == OWN_I);
    bus.d_rvalid = bus.m_rvalid && (rd_owner == OWN_D);
    bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;
  end

  // Next state: a completing read drops back to IDLE, a grant in the same
  // cycle overrides that. Writes finish at grant and never leave IDLE.
  always_comb begin
    state_d = state_q;
    if (bus.m_rvalid && (state_q != IDLE)) begin
      state_d = IDLE;
    end
    if (bus.i_gnt) begin
      state_d = BUSY_I;
    end else if (bus.d_gnt && d_is_read) begin
      state_d = BUSY_D;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      protocol_err <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.m_rvalid && (state_q == IDLE)) begin
        protocol_err <= 1'b1;
      end
    end
  end

  // Fetch starvation guard: counts data grants only while fetch is waiting.
  assign starve_inc = bus.d_gnt && bus.i_req;
  assign starve_clr = bus.i_gnt || !bus.i_req;

  mips_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (starve_at_max)
  );

endmodule

// File: doc/mips_mem_arbiter.md
# mips_mem_arbiter

Shares one single-ported backing memory between the pipeline's instruction-fetch port and its data (load/store) port. Arbitrates per transaction with data-over-instruction priority and a bounded starvation guard for fetch. Tracks the single outstanding read and routes its response to the requester that issued it. Sits between `mips_cpu` and the memory/bus wrapper; the CPU stalls on a missing `*_gnt` or `*_rvalid`.

## Interface
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, data width; byte-lane enables are `DATA_W/8` bits wide
- `STARVE_MAX`, 4, number of consecutive data grants allowed while fetch is pending before fetch is forced; must be ≥1

- `clk` in 1: sole clock; all state changes on the rising edge
- `rst` in 1: asynchronous, active-high reset
- `i_req` in 1: fetch read request, held until `i_gnt`
- `i_addr` in ADDR_W: fetch address
- `i_gnt` out 1: fetch request accepted this cycle
- `i_rvalid` out 1: fetch read data valid (1-cycle pulse)
- `i_rdata` out DATA_W: fetch read data
- `d_req` in 1: data request, held until `d_gnt`
- `d_we` in DATA_W/8: byte write enables; all-zero means read
- `d_addr` in ADDR_W: data address
- `d_wdata` in DATA_W: store data
- `d_gnt` out 1: data request accepted this cycle
- `d_rvalid` out 1: load data valid (1-cycle pulse)
- `d_rdata` out DATA_W: load data
- `m_req` out 1: request to memory
- `m_we` out DATA_W/8: byte enables to memory
- `m_addr` out ADDR_W, `m_wdata` out DATA_W: address and data to memory
- `m_gnt` in 1: memory accepted `m_req` this cycle
- `m_rvalid` in 1: read response valid; reads only, never for writes
- `m_rdata` in DATA_W: read response data
- `protocol_err` out 1: sticky; set on `m_rvalid` with no read outstanding

## Operation
- States: IDLE, BUSY_I (fetch read outstanding), BUSY_D (load outstanding). One outstanding read at most.
- Issue window: IDLE, or BUSY_x in the cycle `m_rvalid`=1. Outside that window `m_req`=0 and both gnts are 0.
- Winner in the issue window:
  - If only one requester is active, that requester wins.
  - If both are active, data wins, unless `starve_cnt`==STARVE_MAX, in which case fetch wins.
- `m_req`/`m_we`/`m_addr`/`m_wdata` are a combinational mux of the winner. Fetch drives `m_we`=0 and `m_wdata`=0.
- `x_gnt` = `m_gnt` & `m_req` & (winner==x).
- Transitions on a granted request:
  - Fetch → BUSY_I.
  - Data read → BUSY_D.
  - Data write → stays in or returns to IDLE; the write is complete at grant.
- `m_rvalid` in BUSY_I → `i_rvalid`=1 and `i_rdata`=`m_rdata`. In BUSY_D → `d_rvalid`/`d_rdata` instead. State then goes to IDLE, unless a new read is granted in the same cycle.
- `m_rdata` is routed combinationally; the non-owner `*_rdata` is 0.
- `m_rvalid` in IDLE: dropped, no `*_rvalid` is produced, and `protocol_err` sets. It clears only on `rst`.
- `starve_cnt` (width clog2(STARVE_MAX+1)):
  - +1 on a data grant while `i_req`=1.
  - Reset to 0 on a fetch grant, or in any cycle with `i_req`=0.
  - Saturates at STARVE_MAX.

## Timing
- Reset values: state IDLE, `starve_cnt`=0, `protocol_err`=0. All outputs are then 0 when requests are 0.
- Request-to-grant latency: 0 cycles (combinational) when the issue window is open and `m_gnt`=1.
- Response-to-requester latency: 0 cycles, because `m_rvalid` is passed through combinationally.
- Back-to-back reads issue with no bubble, using the same-cycle reissue.
- Reset mid-transaction: state is forced to IDLE asynchronously and the outstanding read is forgotten. A late `m_rvalid` then sets `protocol_err`.
- Requesters must hold `req`/addr/data stable until gnt; the arbiter does not latch them.

## Structure
- Shared package `mips_mem_pkg`: state enum (IDLE/BUSY_I/BUSY_D) and owner encoding.
- One sub-module is natural: `mips_starve_ctr`, a saturating counter with inc/clr inputs and an `at_max` output.
- Everything else is a single always_ff for state/err plus combinational mux logic.

## Test plan
- Fetch read alone, `i_addr`=0x100, `m_gnt`=1, memory responds 0xDEADBEEF 2 cycles later → `i_gnt` at cycle 0, `i_rvalid`=1 with `i_rdata`=0xDEADBEEF at cycle 2, `d_rvalid`=0 throughout.
- Simultaneous `i_req`+`d_req` (data read, 0x200) → `d_gnt` first. After `d_rvalid`, `i_gnt` is issued in that same cycle.
- `d_req` write with `d_we`=4'b0010 held continuously, `i_req` held, STARVE_MAX=4 → exactly 4 `d_gnt` pulses, then `i_gnt`. `starve_cnt` returns to 0.
- `m_gnt`=0 for 3 cycles with `d_req` held → no gnt and state stays IDLE. Grant occurs on the first cycle `m_gnt`=1.
- Spurious `m_rvalid` in IDLE → no `*_rvalid`, and `protocol_err`=1 sticky until `rst`.
- Assert `rst` while in BUSY_D, then release, then `m_rvalid` arrives → state IDLE immediately, no `d_rvalid`, and `protocol_err`=1.
